// File: rtl/instr_decode.sv
// Decode-and-issue stage: decodes MIPS words on the write side into a 2-entry in-order buffer feeding the ALU.
// Optional INSTR_DECODE_DROP_ILLEGAL_EN drops illegal words at the input and counts them on illegal_cnt.
module instr_decode #(
   parameter int ID_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [31:0]     in_instr,
   output logic            in_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     ir,
   output logic [ID_W-1:0] instr_ID,
   output logic [4:0]      dest,
   output logic [31:0]     operand_b,
   output logic            illegal
`ifdef INSTR_DECODE_DROP_ILLEGAL_EN
   ,
   output logic [15:0]     illegal_cnt
`endif
);

   typedef struct packed {
      logic [31:0] ir;
      logic [3:0]  id;
      logic [4:0]  dest;
      logic [31:0] opb;
      logic        ill;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t      state_q, state_d;
   entry_t      head_q, head_d, tail_q, tail_d, dec;
   logic [5:0]  opc, fn;
   logic        push, pop, wr;

   always_comb begin
      dec    = '0;
      dec.ir = in_instr;
      opc    = in_instr[31:26];
      fn     = in_instr[5:0];
      if (opc == 6'h00) begin
         case (fn)
            6'h20: dec.id = 4'd1;
            6'h22: dec.id = 4'd2;
            6'h21: dec.id = 4'd3;
            6'h23: dec.id = 4'd4;
            6'h24: dec.id = 4'd7;
            6'h25: dec.id = 4'd8;
            6'h00: begin dec.id = 4'd11; dec.opb = {27'd0, in_instr[10:6]}; end
            6'h02: begin dec.id = 4'd12; dec.opb = {27'd0, in_instr[10:6]}; end
            default: dec.id = 4'd0;
         endcase
      end else begin
         case (opc)
            6'h08: begin dec.id = 4'd5;  dec.opb = {{16{in_instr[15]}}, in_instr[15:0]}; end
            6'h09: begin dec.id = 4'd6;  dec.opb = {{16{in_instr[15]}}, in_instr[15:0]}; end
            6'h0C: begin dec.id = 4'd9;  dec.opb = {16'd0, in_instr[15:0]}; end
            6'h0D: begin dec.id = 4'd10; dec.opb = {16'd0, in_instr[15:0]}; end
            default: dec.id = 4'd0;
         endcase
      end
      dec.ill = (dec.id == 4'd0);
      if (!dec.ill)
         dec.dest = (opc == 6'h00) ? in_instr[15:11] : in_instr[20:16];
   end

   assign in_ready  = (state_q != TWO);
   assign out_valid = (state_q != EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

`ifdef INSTR_DECODE_DROP_ILLEGAL_EN
   logic [15:0] cnt_q, cnt_d;
   assign wr = push & ~dec.ill;
   assign cnt_d = (push && dec.ill && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
   assign illegal_cnt = cnt_q;
   always_ff @(posedge clk) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign wr = push;
`endif

   // Vacated slots are zeroed so the outputs read 0 whenever out_valid is low.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         EMPTY: if (wr) begin head_d = dec; state_d = ONE; end
         ONE: begin
            if (wr && pop)  head_d = dec;
            else if (wr)    begin tail_d = dec; state_d = TWO; end
            else if (pop)   begin head_d = '0; state_d = EMPTY; end
         end
         TWO: if (pop) begin head_d = tail_q; tail_d = '0; state_d = ONE; end
         default: begin state_d = EMPTY; head_d = '0; tail_d = '0; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign ir        = head_q.ir;
   assign instr_ID  = ID_W'(head_q.id);
   assign dest      = head_q.dest;
   assign operand_b = head_q.opb;
   assign illegal   = head_q.ill;

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: queue-based reference model checked every cycle, plus directed literal checks.
module tb_instr_decode;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic        in_ready, out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] ir, instr_ID, operand_b;
   logic [4:0]  dest;
   logic        illegal;
`ifdef INSTR_DECODE_DROP_ILLEGAL_EN
   logic [15:0] illegal_cnt;
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   int checks = 0, failures = 0;
   logic [31:0] q[$];
   int   mcnt = 0;
   bit   started = 0;
   bit   pu, po;

   instr_decode #(.ID_W(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .ir(ir), .instr_ID(instr_ID), .dest(dest), .operand_b(operand_b),
      .illegal(illegal)
`ifdef INSTR_DECODE_DROP_ILLEGAL_EN
      , .illegal_cnt(illegal_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference decode straight from the operation table.
   function automatic void model_dec(input logic [31:0] w, output int id,
                                     output logic [4:0] d, output logic [31:0] b);
      int op, fn;
      op = int'(w[31:26]);
      fn = int'(w[5:0]);
      id = 0;
      if (op == 0) begin
         case (fn)
            32: id = 1;  34: id = 2;  33: id = 3;  35: id = 4;
            36: id = 7;  37: id = 8;  0:  id = 11; 2:  id = 12;
            default: id = 0;
         endcase
      end else begin
         case (op)
            8: id = 5;  9: id = 6;  12: id = 9;  13: id = 10;
            default: id = 0;
         endcase
      end
      if (id == 5 || id == 6)        b = 32'($signed(w[15:0]));
      else if (id == 9 || id == 10)  b = 32'(w[15:0]);
      else if (id == 11 || id == 12) b = 32'(w[10:6]);
      else                           b = 0;
      if (id == 0)      d = 0;
      else if (op == 0) d = w[15:11];
      else              d = w[20:16];
   endfunction

   always @(posedge clk) begin
      int id; logic [4:0] d; logic [31:0] b;
      if (!reset) begin
         q.delete();
         mcnt = 0;
      end else begin
         pu = in_valid && (q.size() < 2);
         po = (q.size() > 0) && out_ready;
         if (po) void'(q.pop_front());
         if (pu) begin
            model_dec(in_instr, id, d, b);
            if (DROP && id == 0) begin
               if (mcnt < 16'hFFFF) mcnt++;
            end else q.push_back(in_instr);
         end
      end
   end

   always @(negedge clk) begin
      int id; logic [4:0] d; logic [31:0] b;
      if (started) begin
         chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
         chk("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
         if (q.size() > 0) begin
            model_dec(q[0], id, d, b);
            chk("m_ir", ir, q[0]);
            chk("m_instr_ID", instr_ID, 32'(id));
            chk("m_dest", 32'(dest), 32'(d));
            chk("m_operand_b", operand_b, b);
            chk("m_illegal", 32'(illegal), 32'(id == 0));
         end else begin
            chk("m_idle_ir", ir, 0);
            chk("m_idle_fields", {instr_ID[15:0], 3'd0, dest, operand_b[6:0], illegal}, 0);
         end
`ifdef INSTR_DECODE_DROP_ILLEGAL_EN
         chk("m_illegal_cnt", 32'(illegal_cnt), 32'(mcnt));
`endif
      end
   end

   task automatic push_word(input logic [31:0] w, input bit rnd);
      int n = 0;
      bit acc = 0;
      in_valid = 1'b1;
      in_instr = w;
      while (!acc && n < 200) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      chk("push_accepted", 32'(acc), 1);
   endtask

   int ops[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 8, 9, 12, 13};
   int fns[12] = '{32, 34, 33, 35, 36, 37, 0, 2, 0, 0, 0, 0};

   initial begin
      logic [31:0] w;
      int k;
      // Reset held two cycles with a word offered.
      in_valid = 1'b1; in_instr = 32'h2128FFFF;
      @(posedge clk); #1; started = 1;
      @(posedge clk); #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_ir", ir, 0);
      chk("rst_fields", instr_ID | operand_b | 32'(dest) | 32'(illegal), 0);
      in_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;

      // Immediate and shift decode, one-cycle latency.
      out_ready = 1'b1;
      push_word(32'h2128FFFF, 0);
      chk("addi_valid", 32'(out_valid), 1);
      chk("addi_id", instr_ID, 5);
      chk("addi_dest", 32'(dest), 8);
      chk("addi_opb", operand_b, 32'hFFFFFFFF);
      push_word(32'h3508FFFF, 0);
      chk("ori_id", instr_ID, 10);
      chk("ori_opb", operand_b, 32'h0000FFFF);
      push_word(32'h00084080, 0);
      chk("sll_id", instr_ID, 11);
      chk("sll_dest", 32'(dest), 8);
      chk("sll_opb", operand_b, 2);
      @(posedge clk); #1;

      // Backpressure: two accepted, third held until the ALU drains.
      out_ready = 1'b0;
      push_word(32'h01095020, 0);
      push_word(32'h25290004, 0);
      chk("bp_full", 32'(in_ready), 0);
      in_valid = 1'b1; in_instr = 32'h00084082;
      repeat (3) begin
         @(posedge clk); #1;
         chk("bp_hold_ready", 32'(in_ready), 0);
         chk("bp_hold_head", ir, 32'h01095020);
      end
      out_ready = 1'b1;
      @(posedge clk); #1; chk("bp_order2", ir, 32'h25290004);
      @(posedge clk); #1; in_valid = 1'b0;
      chk("bp_order3", ir, 32'h00084082);
      chk("bp_order3_id", instr_ID, 12);
      @(posedge clk); #1; chk("bp_drained", 32'(out_valid), 0);

      // Random legal stream with random out_ready.
      for (int i = 0; i < 100; i++) begin
         k = $urandom_range(0, 11);
         w = $urandom;
         w[31:26] = 6'(ops[k]);
         if (ops[k] == 0) w[5:0] = 6'(fns[k]);
         push_word(w, 1);
      end
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1; chk("stream_drained", 32'(out_valid), 0);

      // Illegal word.
      out_ready = 1'b0;
      push_word(32'hFC000000, 0);
`ifdef INSTR_DECODE_DROP_ILLEGAL_EN
      chk("ill_dropped", 32'(out_valid), 0);
      chk("ill_cnt1", 32'(illegal_cnt), 1);
      in_valid = 1'b1;
      repeat (70000) @(posedge clk);
      #1; in_valid = 1'b0;
      chk("ill_cnt_sat", 32'(illegal_cnt), 32'hFFFF);
`else
      chk("ill_valid", 32'(out_valid), 1);
      chk("ill_flag", 32'(illegal), 1);
      chk("ill_id", instr_ID, 0);
      chk("ill_dest", 32'(dest), 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
`endif

      // Reset mid-operation discards buffered entries and ignores the handshake.
      out_ready = 1'b0;
      push_word(32'h3508FFFF, 0);
      push_word(32'h2128FFFF, 0);
      reset = 1'b0; in_valid = 1'b1; in_instr = 32'h01095020;
      @(posedge clk); #1;
      reset = 1'b1; in_valid = 1'b0;
      chk("midrst_valid", 32'(out_valid), 0);
      chk("midrst_ready", 32'(in_ready), 1);
      chk("midrst_ir", ir, 0);
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_decode.md
# instr_decode

Instruction decode-and-issue stage that feeds the ALU. It accepts raw 32-bit MIPS instruction words from fetch over a valid/ready handshake and decodes opcode/funct into the ALU's numeric `instr_ID` (1–12). It also extracts the destination register and the second operand (extended immediate or shift amount). Results are held in a 2-entry in-order buffer so the ALU can stall without losing instructions.

## Interface
- `ID_W`, 32: width of `instr_ID` output.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `in_valid`  in  1  fetch presents `in_instr`.
- `in_instr`  in  32  raw instruction word.
- `in_ready`  out  1  block can accept this cycle.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  ALU consumes head entry.
- `ir`  out  32  head instruction word, unmodified.
- `instr_ID`  out  ID_W  decoded operation code (0 = illegal).
- `dest`  out  5  rd for R-type, rt for I-type.
- `operand_b`  out  32  extended immediate or shift amount; 0 for R-type arithmetic/logic.
- `illegal`  out  1  head entry failed decode.

## Operation
- Decode (opcode `ir[31:26]`, funct `ir[5:0]`):
  - opcode 0x00: funct 0x20→1 add, 0x22→2 sub, 0x21→3 addu, 0x23→4 subu, 0x24→7 and, 0x25→8 or, 0x00→11 sll, 0x02→12 srl.
  - opcode 0x08→5 addi, 0x09→6 addiu, 0x0C→9 andi, 0x0D→10 ori.
  - Anything else: `instr_ID`=0, `illegal`=1.
- `operand_b`:
  - addi/addiu: sign-extend `ir[15:0]`.
  - andi/ori: zero-extend `ir[15:0]`.
  - sll/srl: zero-extend `ir[10:6]`.
  - All other cases: 0.
- `dest`: `ir[15:11]` for opcode 0; `ir[20:16]` otherwise; 0 when illegal.
- Decode happens on the write side. The buffer stores decoded fields, not raw words only.
- Occupancy FSM:
  - States: EMPTY, ONE, TWO.
  - push = `in_valid & in_ready`; pop = `out_valid & out_ready`.
  - EMPTY: push→ONE.
  - ONE: push&!pop→TWO; !push&pop→EMPTY; push&pop→ONE, new entry becomes head next cycle.
  - TWO: pop→ONE; push impossible.
- `in_ready` = state != TWO, driven from a state register; it has no combinational path from `out_ready`.
- `out_valid` = state != EMPTY.
- Output order is strictly FIFO. Head outputs are stable while `out_valid & !out_ready`.

## Timing
- Latency: a word accepted at edge N is visible on `ir`/`instr_ID` with `out_valid`=1 in the cycle after edge N, when the buffer was EMPTY.
- Throughput: one instruction per cycle when `out_ready` is held at 1.
- Reset (`reset`=0 at an edge):
  - State→EMPTY; all entries cleared.
  - Outputs: `out_valid`=0, `in_ready`=1, `ir`=0, `instr_ID`=0, `dest`=0, `operand_b`=0, `illegal`=0.
  - Reset mid-operation discards all buffered entries. A handshake in the reset cycle is ignored.
- Simultaneous push and pop in ONE: occupancy stays 1; head advances to the new word.
- `in_valid` while in TWO: no acceptance; fetch must hold its word.
- Outputs are X-free whenever `out_valid`=0. They hold the last cleared or popped value's reset value (0).

## Configuration
- `INSTR_DECODE_DROP_ILLEGAL_EN`
  - Defined: illegal words are accepted (`in_ready` honoured) but never enter the buffer, so `out_valid` never presents `illegal`=1. A 16-bit saturating counter `illegal_cnt` (extra output port, reset 0) increments per dropped word.
  - Undefined: illegal words are buffered and issued with `instr_ID`=0, `illegal`=1. The `illegal_cnt` port does not exist.

## Test plan
- **Reset behaviour:** hold `reset`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `in_ready`=1, all outputs 0.
- **Immediate decode:** push 0x2128FFFF (addi rt=8, imm -1) with `out_ready`=1 → next cycle `instr_ID`=5, `dest`=8, `operand_b`=0xFFFFFFFF. Then push 0x3508FFFF (ori) → `instr_ID`=10, `operand_b`=0x0000FFFF.
- **Shift decode:** push 0x00084080 (sll rd=8, shamt=2) → `instr_ID`=11, `dest`=8, `operand_b`=2.
- **Backpressure:** hold `out_ready`=0 and push 3 words back-to-back → `in_ready` drops after 2 accepted. Third word stays pending. Release `out_ready` → words issue in order 1, 2, 3, one per cycle.
- **Simultaneous push/pop:** stream 100 random legal words with `out_ready` toggling randomly → every word issued exactly once, in order, decode matches model.
- **Illegal words:** push 0xFC000000 →
  - macro undefined: issued with `instr_ID`=0, `illegal`=1.
  - macro defined: not issued, `illegal_cnt`=1. After 70000 illegal pushes, `illegal_cnt`=0xFFFF.
